sram_like_slave: RTL and testbench

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

---
 rtl/sram_like_slave.sv | 176 +++++++++++++++++
 tb/tb_sram_like_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// SRAM-style slave: in-order request queue, fixed head latency, byte-lane writes.
// Optional macro SRAM_LIKE_SLAVE_RANDOM_DELAY_EN adds LFSR-driven latency jitter and addr_ok stalls.
module sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W = 3;
    localparam int PTR_W = 2;
    localparam int TMR_W = 5;
    localparam int QN    = 4;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [TMR_W-1:0] LOAD_C   = TMR_W'(LATENCY - 1);

    // Handshake: a request transfers on a cycle where req and addr_ok are both 1;
    // addr_ok never depends on req, and data_ok retires the oldest accepted request.

    logic              q_wr_q    [QN];
    logic [1:0]        q_size_q  [QN];
    logic [1:0]        q_lo_q    [QN];
    logic [ADDR_W-1:0] q_idx_q   [QN];
    logic [31:0]       q_wdata_q [QN];

    logic [31:0]       mem_q [2**ADDR_W];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rdy_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              retire;
    logic              addr_ok_w;
    logic [TMR_W-1:0]  load_val;
    logic              head_wr;
    logic [1:0]        head_size;
    logic [1:0]        head_lo;
    logic [ADDR_W-1:0] head_idx;
    logic [31:0]       head_wdata;
    logic [3:0]        be;
    logic              addr_unused;

    assign addr_unused = ^{addr[31:ADDR_W+2]};

`ifdef SRAM_LIKE_SLAVE_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign addr_ok_w = rdy_q && (count_q < DEPTH_C) && !lfsr_q[2];
    assign load_val  = LOAD_C + TMR_W'(lfsr_q[1:0]);
`else
    assign addr_ok_w = rdy_q && (count_q < DEPTH_C);
    assign load_val  = LOAD_C;
`endif

    assign accept  = req && addr_ok_w;
    assign retire  = (count_q != '0) && (timer_q == '0);
    assign addr_ok = addr_ok_w;
    assign data_ok = retire;

    assign head_wr    = q_wr_q[head_q];
    assign head_size  = q_size_q[head_q];
    assign head_lo    = q_lo_q[head_q];
    assign head_idx   = q_idx_q[head_q];
    assign head_wdata = q_wdata_q[head_q];

    // Read data is only presented for a retiring read; otherwise the last read word is held.
    assign rdata = (retire && !head_wr) ? mem_q[head_idx] : rdata_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        case (head_size)
            2'd0:    be = 4'b0001 << head_lo;
            2'd1:    be = head_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        timer_d = timer_q;
        if (accept) begin
            tail_d = ptr_inc(tail_q);
        end
        if (retire) begin
            head_d = ptr_inc(head_q);
        end
        case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The timer restarts whenever a new entry reaches the head of the queue.
        if (retire) begin
            if ((count_q > CNT_W'(1)) || accept) begin
                timer_d = load_val;
            end else begin
                timer_d = '0;
            end
        end else if (accept && (count_q == '0)) begin
            timer_d = load_val;
        end else if ((count_q != '0) && (timer_q != '0)) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            timer_q <= '0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            timer_q <= timer_d;
            rdy_q   <= 1'b1;
            if (retire && !head_wr) begin
                rdata_q <= mem_q[head_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr_q[tail_q]    <= wr;
            q_size_q[tail_q]  <= size;
            q_lo_q[tail_q]    <= addr[1:0];
            q_idx_q[tail_q]   <= addr[ADDR_W+1:2];
            q_wdata_q[tail_q] <= wdata;
        end
    end

    // Memory has no reset so its contents survive rst; retire is held low during reset.
    always_ff @(posedge clk) begin
        if (retire && head_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[head_idx][i*8 +: 8] <= head_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Randomised bench for sram_like_slave against a transaction-level queue/memory model.
module tb_sram_like_slave;

    localparam int AW      = 10;
    localparam int LAT     = 4;
    localparam int DEP     = 2;
    localparam int MAX_CYC = 20000;
`ifdef SRAM_LIKE_SLAVE_RANDOM_DELAY_EN
    localparam int SLACK = 3;
`else
    localparam int SLACK = 0;
`endif

    localparam logic [1:0] K_REQ   = 2'd0;
    localparam logic [1:0] K_IDLE  = 2'd1;
    localparam logic [1:0] K_DRAIN = 2'd2;
    localparam logic [1:0] K_RST   = 2'd3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic [1:0]  size  = 2'd0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sram_like_slave #(.ADDR_W(AW), .LATENCY(LAT), .DEPTH(DEP)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] kval;
    } drv_t;

    typedef struct packed {
        logic [31:0] acc;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] kval;
    } exp_t;

    drv_t        drv_q[$];
    exp_t        exp_q[$];
    drv_t        cur;
    logic        cur_valid = 1'b0;
    logic [31:0] ref_mem [2**AW];
    logic [31:0] hold_rdata = 32'd0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rel_cyc  = 0;
    int          last_ret = 0;
    int          rst_cnt  = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] m;
        case (sz)
            2'd0:    m = 32'h0000_00FF << (8 * lo);
            2'd1:    m = 32'h0000_FFFF << (16 * lo[1]);
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old & ~m) | (nw & m);
    endfunction

    task automatic push_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] d, input logic c, input logic [31:0] k);
        drv_t it;
        it = '{kind: K_REQ, wr: w, size: s, addr: a, wdata: d, chk: c, kval: k};
        drv_q.push_back(it);
    endtask

    task automatic push_kind(input logic [1:0] k);
        drv_t it;
        it = '0;
        it.kind = k;
        drv_q.push_back(it);
    endtask

    task automatic monitor();
        exp_t        h;
        int          start;
        int          lat;
        logic        rd_now;
        logic        exp_ok;
        logic [31:0] idx;
        rd_now = 1'b0;
        if (!rst) begin
            check("rst_addr_ok", 32'(addr_ok), 32'd0);
            check("rst_data_ok", 32'(data_ok), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            return;
        end
        exp_ok = (cyc > rel_cyc) && (exp_q.size() < DEP);
`ifdef SRAM_LIKE_SLAVE_RANDOM_DELAY_EN
        if (!exp_ok) check("addr_ok", 32'(addr_ok), 32'd0);
`else
        check("addr_ok", 32'(addr_ok), 32'(exp_ok));
`endif
        if (exp_q.size() == 0) begin
            check("data_ok_idle", 32'(data_ok), 32'd0);
        end else begin
            h = exp_q[0];
            start = (int'(h.acc) > last_ret) ? int'(h.acc) : last_ret;
            lat = cyc - start;
            if (lat < LAT) check("data_ok_early", 32'(data_ok), 32'd0);
            else if (lat == LAT + SLACK) check("data_ok_due", 32'(data_ok), 32'd1);
            if ((lat >= LAT) && (data_ok || (lat == LAT + SLACK))) begin
                idx = 32'(h.addr[AW+1:2]);
                if (h.wr) begin
                    ref_mem[idx] = merge(ref_mem[idx], h.wdata, h.size, h.addr[1:0]);
                end else begin
                    check("rdata", rdata, ref_mem[idx]);
                    if (h.chk) check("rdata_scenario", rdata, h.kval);
                    hold_rdata = ref_mem[idx];
                    rd_now = 1'b1;
                end
                last_ret = cyc;
                void'(exp_q.pop_front());
            end
        end
        if (!rd_now) check("rdata_hold", rdata, hold_rdata);
    endtask

    task automatic drive();
        drv_t it;
        exp_t e;
        if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) begin
                rst = 1'b1;
                rel_cyc = cyc;
            end
            return;
        end
        if (!cur_valid) begin
            req = 1'b0;
            if (drv_q.size() != 0) begin
                it = drv_q[0];
                case (it.kind)
                    K_REQ: begin
                        void'(drv_q.pop_front());
                        cur = it;
                        cur_valid = 1'b1;
                        req = 1'b1;
                        wr = it.wr;
                        size = it.size;
                        addr = it.addr;
                        wdata = it.wdata;
                    end
                    K_IDLE: void'(drv_q.pop_front());
                    K_DRAIN: if (exp_q.size() == 0) void'(drv_q.pop_front());
                    default: begin
                        if (exp_q.size() == DEP) begin
                            void'(drv_q.pop_front());
                            rst = 1'b0;
                            rst_cnt = 3;
                            exp_q.delete();
                            hold_rdata = 32'd0;
                            last_ret = 0;
                            return;
                        end
                    end
                endcase
            end
        end
        if (req && addr_ok) begin
            e = '{acc: 32'(cyc), wr: cur.wr, size: cur.size, addr: cur.addr,
                  wdata: cur.wdata, chk: cur.chk, kval: cur.kval};
            exp_q.push_back(e);
            cur_valid = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) push_req(1'b1, 2'd2, 32'(i * 4), $urandom, 1'b0, 32'd0);
        push_kind(K_DRAIN);
        push_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF);
        push_kind(K_DRAIN);
        push_req(1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, 32'd0);
        push_req(1'b1, 2'd0, 32'h21, 32'h0000AA00, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h20, 32'd0, 1'b1, 32'h1122AA44);
        push_req(1'b1, 2'd1, 32'h22, 32'hBBBB0000, 1'b0, 32'd0);
        push_req(1'b0, 2'd0, 32'h23, 32'd0, 1'b1, 32'hBBBBAA44);
        push_req(1'b1, 2'd2, 32'h1000, 32'h5A5A5A5A, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h0, 32'd0, 1'b1, 32'h5A5A5A5A);
        push_kind(K_DRAIN);
        push_req(1'b0, 2'd2, 32'h0, 32'd0, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h4, 32'd0, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h8, 32'd0, 1'b0, 32'd0);
        push_kind(K_DRAIN);
        push_req(1'b1, 2'd2, 32'h28, 32'hCAFE0001, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h0C, 32'd0, 1'b0, 32'd0);
        push_kind(K_RST);
        push_req(1'b0, 2'd2, 32'h28, 32'd0, 1'b0, 32'd0);
        push_req(1'b0, 2'd2, 32'h0, 32'd0, 1'b1, 32'h5A5A5A5A);
        push_kind(K_DRAIN);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) push_kind(K_IDLE);
            push_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)),
                     ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                         | 32'($urandom_range(0, 3)),
                     $urandom, 1'b0, 32'd0);
        end
        while ((cyc < MAX_CYC) &&
               !((drv_q.size() == 0) && !cur_valid && (exp_q.size() == 0) && (rst_cnt == 0))) begin
            @(negedge clk);
            cyc++;
            monitor();
            drive();
        end
        check("left_pending", 32'(drv_q.size() + exp_q.size()), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cyc++;
            monitor();
            drive();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
